// File: rtl/vscale_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the size and state encodings, the counter width, the data-phase
// register layout and the address range check.
package vscale_dmem_responder_pkg;

  localparam logic [2:0] MEM_SIZE_B = 3'd0;
  localparam logic [2:0] MEM_SIZE_H = 3'd1;
  localparam logic [2:0] MEM_SIZE_W = 3'd2;

  localparam int unsigned DMEM_STATE_W = 2;
  localparam int unsigned DMEM_CNT_W   = 4;

  typedef enum logic [DMEM_STATE_W-1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_LAST = 2'd2
  } dmem_state_e;

  // Request-phase fields captured for use in the data phase.
  typedef struct packed {
    logic       wen;
    logic [2:0] size;
    logic [1:0] lo;
    logic       oob;
  } dmem_phase_t;

  // The offset is relative to the base, so addresses below the base wrap
  // to large values and are flagged along with those past the end.
  function automatic logic addr_oob(input logic [31:0] offset,
                                    input logic [32:0] span);
    return {1'b0, offset} >= span;
  endfunction

endpackage

// File: rtl/vscale_dmem_responder_if.sv
// Two-phase data-memory bus between the core (master) and the memory
// responder (slave).
//   dmem_en/wen/size/addr : request phase, driven by the core
//   dmem_wdata            : store data, data phase, driven by the core
//   dmem_rdata            : load data, data phase, driven by the memory
//   dmem_wait             : data phase stalled
//   dmem_badmem_e         : data-phase access error
interface vscale_dmem_responder_if;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;

  modport master (
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_wait, dmem_badmem_e
  );

  modport slave (
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_wait, dmem_badmem_e
  );
endinterface

// File: rtl/vscale_dmem_responder_lane_ctrl.sv
// Byte-lane decode for a data-phase access.
//   size, lo      : access size and byte offset within the word
//   wdata         : unshifted store data
//   byte_en       : lanes written by a store
//   wdata_rep     : store data replicated across all lanes
//   misalign      : illegal size or misaligned address
module vscale_dmem_lane_ctrl
  import vscale_dmem_responder_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic        misalign
);

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size)
      MEM_SIZE_B: begin
        byte_en   = 4'b0001 << lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MEM_SIZE_H: begin
        byte_en   = lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = lo[0];
      end
      MEM_SIZE_W: begin
        byte_en  = 4'b1111;
        misalign = (lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Data-memory responder: word array with configurable wait states,
// byte-lane store merging and access-error reporting.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave end of the two-phase dmem interface
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic                     clk,
  input logic                     reset,
  vscale_dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
  localparam logic [DMEM_CNT_W-1:0] WAIT_INIT = DMEM_CNT_W'(WAIT_CYCLES);
  localparam dmem_state_e FIRST_STATE = (WAIT_CYCLES > 0) ? DMEM_BUSY : DMEM_LAST;

  dmem_state_e           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  dmem_phase_t           ph_q;
  logic [IDX_W-1:0]      idx_q;
  logic [31:0]           mem [DEPTH_WORDS];

  logic [31:0] offset;
  logic        req_oob;
  logic        accept;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;
  logic        misalign;
  logic        err;
  logic        mem_we;

  assign offset  = bus.dmem_addr - BASE_ADDR;
  assign req_oob = addr_oob(offset, SPAN);
  assign accept  = bus.dmem_en && (state_q != DMEM_BUSY);
  assign err     = ph_q.oob | misalign;

  vscale_dmem_lane_ctrl u_lane_ctrl (
    .size      (ph_q.size),
    .lo        (ph_q.lo),
    .wdata     (bus.dmem_wdata),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .misalign  (misalign)
  );

  // State register plus data-phase capture; out-of-range requests keep
  // index 0 so they never address the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ph_q  <= '{wen: bus.dmem_wen, size: bus.dmem_size,
                   lo: offset[1:0], oob: req_oob};
        idx_q <= req_oob ? '0 : offset[IDX_W+1:2];
      end
    end
  end

  // Next-state: LAST accepts a new request on its final edge (no bubble).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE, DMEM_LAST: begin
        if (accept) begin
          state_d = FIRST_STATE;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = DMEM_IDLE;
          cnt_d   = '0;
        end
      end
      DMEM_BUSY: begin
        cnt_d = cnt_q - DMEM_CNT_W'(1);
        if (cnt_q <= DMEM_CNT_W'(1)) state_d = DMEM_LAST;
      end
      default: begin
        state_d = DMEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.dmem_wait     = 1'b0;
    bus.dmem_badmem_e = 1'b0;
    bus.dmem_rdata    = '0;
    mem_we            = 1'b0;
    case (state_q)
      DMEM_BUSY: bus.dmem_wait = 1'b1;
      DMEM_LAST: begin
        bus.dmem_badmem_e = err;
        bus.dmem_rdata    = err ? 32'h0 : mem[idx_q];
        mem_we            = ph_q.wen && !err;
      end
      default: ;
    endcase
  end

  // Array write at the edge ending LAST; a concurrent reset drops it.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx_q][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: three instances (0, 2 and 3 wait
// states), directed scenarios followed by random accesses checked against
// a byte-level memory model.
module tb_vscale_dmem_responder;

  localparam int unsigned DEPTH = 64;

  logic clk;
  logic reset;

  vscale_dmem_responder_if b0 ();
  vscale_dmem_responder_if b2 ();
  vscale_dmem_responder_if b3 ();

  vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(2))
    u2 (.clk(clk), .reset(reset), .bus(b2));
  vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(3))
    u3 (.clk(clk), .reset(reset), .bus(b3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int waits [3] = '{0, 2, 3};
  logic [31:0] mdl   [3][DEPTH];
  bit          known [3][DEPTH];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int s, input logic en, input logic wen,
                           input logic [2:0] size, input logic [31:0] addr);
    case (s)
      0: begin b0.dmem_en = en; b0.dmem_wen = wen; b0.dmem_size = size; b0.dmem_addr = addr; end
      1: begin b2.dmem_en = en; b2.dmem_wen = wen; b2.dmem_size = size; b2.dmem_addr = addr; end
      default: begin b3.dmem_en = en; b3.dmem_wen = wen; b3.dmem_size = size; b3.dmem_addr = addr; end
    endcase
  endtask

  task automatic drive_wdata(input int s, input logic [31:0] d);
    case (s)
      0: b0.dmem_wdata = d;
      1: b2.dmem_wdata = d;
      default: b3.dmem_wdata = d;
    endcase
  endtask

  function automatic logic [31:0] obs_rdata(input int s);
    case (s)
      0: return b0.dmem_rdata;
      1: return b2.dmem_rdata;
      default: return b3.dmem_rdata;
    endcase
  endfunction

  function automatic logic obs_wait(input int s);
    case (s)
      0: return b0.dmem_wait;
      1: return b2.dmem_wait;
      default: return b3.dmem_wait;
    endcase
  endfunction

  function automatic logic obs_bad(input int s);
    case (s)
      0: return b0.dmem_badmem_e;
      1: return b2.dmem_badmem_e;
      default: return b3.dmem_badmem_e;
    endcase
  endfunction

  // Access legality from the size/alignment/range rules (base 0).
  function automatic logic model_err(input logic [2:0] size, input logic [31:0] addr);
    return (size > 3'd2) || (size == 3'd1 && addr[0]) ||
           (size == 3'd2 && addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
  endfunction

  // Store merge expressed byte by byte.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] size,
                                        input logic [1:0] lo, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (size == 3'd0 && b == int'(lo)) r[8*b +: 8] = wd[7:0];
      else if (size == 3'd1 && (b / 2) == int'(lo[1])) r[8*b +: 8] = wd[8*(b%2) +: 8];
      else if (size == 3'd2) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // One isolated access: request, wait out the stall, check LAST, update model.
  task automatic access(input int s, input logic wen, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int n;
    int w;
    logic e;
    @(negedge clk);
    drive_req(s, 1'b1, wen, size, addr);
    @(posedge clk);
    @(negedge clk);
    drive_req(s, 1'b0, 1'b0, 3'd0, 32'h0);
    drive_wdata(s, wdata);
    n = 0;
    while (obs_wait(s) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_waits"}, 32'(n), 32'(waits[s]));
    e = model_err(size, addr);
    w = int'(addr[7:2]);
    check({tag, "_bad"}, 32'(obs_bad(s)), 32'(e));
    last_rdata = obs_rdata(s);
    if (e) check({tag, "_rdata"}, last_rdata, 32'h0);
    else if (known[s][w]) check({tag, "_rdata"}, last_rdata, mdl[s][w]);
    if (wen && !e) begin
      mdl[s][w]   = merge(mdl[s][w], size, addr[1:0], wdata);
      known[s][w] = known[s][w] || (size == 3'd2);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      drive_req(s, 1'b0, 1'b0, 3'd0, 32'h0);
      drive_wdata(s, 32'h0);
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_wait", 32'(obs_wait(s)), 32'h0);
      check("rst_bad", 32'(obs_bad(s)), 32'h0);
      check("rst_rdata", obs_rdata(s), 32'h0);
    end
    reset = 1'b0;

    // Prefill the 16-word random window of every instance.
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 16; i++)
        access(s, 1'b1, 3'd2, 32'(i * 4), $urandom, "fill");

    // Back-to-back store then load with no wait states.
    @(negedge clk);
    drive_req(0, 1'b1, 1'b1, 3'd2, 32'h10);
    @(posedge clk);
    @(negedge clk);
    check("b2b_st_wait", 32'(obs_wait(0)), 32'h0);
    drive_wdata(0, 32'hDEADBEEF);
    drive_req(0, 1'b1, 1'b0, 3'd2, 32'h10);
    @(posedge clk);
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 3'd0, 32'h0);
    check("b2b_ld_wait", 32'(obs_wait(0)), 32'h0);
    check("b2b_ld_rdata", obs_rdata(0), 32'hDEADBEEF);
    check("b2b_ld_bad", 32'(obs_bad(0)), 32'h0);
    mdl[0][4] = 32'hDEADBEEF;

    // Byte and half-word merges.
    access(0, 1'b1, 3'd2, 32'h10, 32'h11223344, "st_w");
    access(0, 1'b1, 3'd0, 32'h13, 32'h000000A5, "st_b");
    access(0, 1'b0, 3'd2, 32'h10, 32'h0, "ld_b");
    check("merge_byte", last_rdata, 32'hA5223344);
    access(0, 1'b1, 3'd1, 32'h12, 32'h00005A5A, "st_h");
    access(0, 1'b0, 3'd2, 32'h10, 32'h0, "ld_h");
    check("merge_half", last_rdata, 32'h5A5A3344);

    // Error cases, then a normal access.
    access(0, 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, "err_h_mis");
    access(0, 1'b0, 3'd2, 32'h10, 32'h0, "after_err");
    check("err_unchanged", last_rdata, 32'h5A5A3344);
    access(0, 1'b0, 3'd2, 32'h0E, 32'h0, "err_w_mis");
    access(0, 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, "err_oob");
    access(0, 1'b0, 3'd3, 32'h10, 32'h0, "err_size");
    access(0, 1'b0, 3'd2, 32'h14, 32'h0, "post_err");

    // Three wait states; second request held through the stall.
    @(negedge clk);
    drive_req(2, 1'b1, 1'b0, 3'd2, 32'h10);
    @(posedge clk);
    @(negedge clk);
    drive_req(2, 1'b1, 1'b0, 3'd2, 32'h14);
    n = 0;
    while (obs_wait(2) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("hold_waits1", 32'(n), 32'd3);
    check("hold_rdata1", obs_rdata(2), mdl[2][4]);
    @(negedge clk);
    check("hold_accepted", 32'(obs_wait(2)), 32'h1);
    drive_req(2, 1'b0, 1'b0, 3'd0, 32'h0);
    n = 0;
    while (obs_wait(2) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("hold_waits2", 32'(n), 32'd3);
    check("hold_rdata2", obs_rdata(2), mdl[2][5]);

    // Reset during the stall of a store drops it.
    access(1, 1'b1, 3'd2, 32'h20, 32'h01020304, "rst_pre");
    @(negedge clk);
    drive_req(1, 1'b1, 1'b1, 3'd2, 32'h20);
    @(posedge clk);
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, 3'd0, 32'h0);
    drive_wdata(1, 32'hCAFEF00D);
    check("rst_busy_wait", 32'(obs_wait(1)), 32'h1);
    reset = 1'b1;
    #1;
    check("rst_mid_wait", 32'(obs_wait(1)), 32'h0);
    check("rst_mid_bad", 32'(obs_bad(1)), 32'h0);
    check("rst_mid_rdata", obs_rdata(1), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    access(1, 1'b0, 3'd2, 32'h20, 32'h0, "rst_post");
    check("rst_word_kept", last_rdata, 32'h01020304);

    // Random mix of sizes, alignments and ranges.
    for (int i = 0; i < 150; i++) begin
      int s;
      logic [2:0] sz;
      logic [31:0] a;
      s  = int'($urandom_range(0, 2));
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, 63));
      access(s, 1'($urandom_range(0, 1)), sz, a, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vscale_dmem_responder.md
Name: vscale_dmem_responder

Overview:
Memory-side responder for the core's two-phase data-memory interface. The request phase (en/wen/size/addr) arrives in DX; the data phase (store data in, load data out) completes in WB. The block holds a word-addressed storage array, inserts a configurable number of wait states, performs byte-lane store merging and flags bad accesses back to the core. It is the slave end of the dmem_en / dmem_wait / dmem_badmem_e handshake and is used in the testbench and single-chip top level.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned)
WAIT_CYCLES, 0, wait states inserted per access (0..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dmem_en  in  1  request-phase valid
dmem_wen  in  1  request is a store
dmem_size  in  3  0=byte, 1=half, 2=word, others illegal
dmem_addr  in  32  byte address, request phase
dmem_wdata  in  32  store data, unshifted (low bits significant), data phase
dmem_rdata  out  32  aligned full word at the data-phase address
dmem_wait  out  1  data phase not yet complete; core holds WB and DX
dmem_badmem_e  out  1  data-phase access error, valid when dmem_wait=0

Behaviour:
- Reset is asynchronous, active-high, and clears all control state. State=IDLE, counter=0, dmem_wait=0, dmem_badmem_e=0, dmem_rdata=0. Array contents are not reset. Reset asserted mid-access drops the access; no write occurs.
- Acceptance: a request is accepted on a rising edge when dmem_en=1 and dmem_wait=0. The edge registers addr, wen, size and an error flag into data-phase registers and loads the counter with WAIT_CYCLES.
- States:
  - IDLE: no data phase.
  - BUSY: data phase with counter>0.
  - LAST: final data-phase cycle.
- Transitions:
  - From IDLE on accept: go to BUSY if WAIT_CYCLES>0, else LAST.
  - BUSY: decrement the counter each cycle. When it reaches 1, go to LAST on the next edge.
  - LAST: go to LAST/BUSY if a new request is accepted on the same edge (back-to-back, no bubble), else IDLE.
- dmem_wait = (state==BUSY). Requests seen while dmem_wait=1 are ignored; the core holds them stable.
- Error flag is set if any of the following holds:
  - size>2
  - size=1 and addr[0]=1
  - size=2 and addr[1:0]!=0
  - addr outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4)
  dmem_badmem_e equals the flag in LAST and is 0 otherwise.
- Store commit: at the edge ending LAST, if wen=1 and no error, write the active lanes.
  - Byte: lane=addr[1:0], data {4{wdata[7:0]}}.
  - Half: lanes addr[1]*2 and +1, data {2{wdata[15:0]}}.
  - Word: all lanes.
  - Errored stores never modify the array.
- Load data: dmem_rdata = array[word index] combinationally in LAST, 0 in other states. For errored accesses it is 0.
- Read-after-write: a load whose LAST follows a store's LAST to the same word returns the merged new word.
- Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. Out-of-range addresses are never used to index the array.

Decomposition:
- Header vscale_dmem_constants.vh holds:
  - size encodings (MEM_SIZE_B/H/W)
  - state encodings (DMEM_IDLE/BUSY/LAST) and state width
  - counter width (4)
- Sub-module vscale_dmem_lane_ctrl is combinational. From size and addr[1:0] it produces the 4-bit byte enable, the replicated write data and the misalign flag. The responder instantiates it on the data-phase registers.

Test Plan:
- WAIT_CYCLES=0: store word 32'hDEADBEEF @0x10, then load @0x10 back-to-back -> dmem_wait never 1; second LAST gives rdata=32'hDEADBEEF, badmem_e=0.
- Store byte 8'hA5 @0x13 onto word 0x11223344 @0x10, then load word -> rdata=32'hA5223344. Store half 16'h5A5A @0x12 -> 32'h5A5A3344.
- WAIT_CYCLES=3: accept load -> dmem_wait=1 for exactly 3 cycles, then LAST with rdata valid. A request held during wait is accepted only on the LAST edge.
- Half store @0x11 and word load @0x0E -> badmem_e=1 in LAST, dmem_wait=0, array word unchanged. Load @BASE_ADDR+DEPTH_WORDS*4 -> badmem_e=1, rdata=0.
- size=3 request -> badmem_e=1; the next valid request proceeds normally.
- Assert reset during BUSY of a store (WAIT_CYCLES=2) -> outputs 0 immediately, state IDLE, target word unchanged.
